three_level_modulator: RTL

THREE_LEVEL_MODULATOR -- requirements
Module: three_level_modulator

---
 rtl/three_level_modulator_if.sv | 27 ++
 rtl/three_level_modulator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/three_level_modulator_if.sv
// Signal bundle between a converter controller and the three-level modulator.
// Signal names match the original flat port list so existing connections map
// one-to-one onto interface members.
interface three_level_modulator_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_enable;
  logic [CNT_W-1:0] i_half_period;
  logic [CNT_W-1:0] i_zero_time;
  logic [3:0]       o_mosfet;
  logic [2:0]       o_state;
  logic             o_sync;
  logic             o_clamp;
  logic             o_alert;

  // Controller side: drives settings/enable, observes gate commands and status.
  modport master (
    output i_enable, i_half_period, i_zero_time,
    input  o_mosfet, o_state, o_sync, o_clamp, o_alert
  );

  // Modulator side.
  modport slave (
    input  i_enable, i_half_period, i_zero_time,
    output o_mosfet, o_state, o_sync, o_clamp, o_alert
  );
endinterface

// File: rtl/three_level_modulator.sv
// Three-level H-bridge modulator: POS -> ZERO_A -> NEG -> ZERO_B -> POS,
// each step toggling a single leg. Timing settings are captured once per
// switching period so mid-period changes never distort the waveform.
// Legs: A = Q1/Q3 (bits 0/2), B = Q2/Q4 (bits 1/3).
module three_level_modulator #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  three_level_modulator_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POS    = 3'd1,
    ZERO_A = 3'd2,
    NEG    = 3'd3,
    ZERO_B = 3'd4
  } state_t;

  state_t           state;
  state_t           nxt;
  logic             latch;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hp_sh;
  logic [CNT_W-1:0] zero_sh;
  logic [CNT_W-1:0] pos_last;
  logic [CNT_W-1:0] zero_last;
  logic [CNT_W-1:0] hp_eff;
  logic [CNT_W-1:0] zero_max;
  logic [CNT_W-1:0] zero_eff;
  logic             clamp_now;
  logic [3:0]       mosfet_r;
  logic             sync_r;
  logic             clamp_r;
  logic             alert_r;

  function automatic logic [3:0] leg_code(input state_t s);
    logic [3:0] code;
    case (s)
      POS:     code = 4'b0011;
      ZERO_A:  code = 4'b1001;
      NEG:     code = 4'b1100;
      ZERO_B:  code = 4'b0110;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  // Effective settings derived from the live inputs; only used at latch time.
  always_comb begin
    hp_eff    = bus.i_half_period;
    clamp_now = 1'b0;
    if (bus.i_half_period < CNT_W'(2)) begin
      hp_eff    = CNT_W'(2);
      clamp_now = 1'b1;
    end
    zero_max = hp_eff - CNT_W'(1);
    zero_eff = bus.i_zero_time;
    if (bus.i_zero_time > zero_max) begin
      zero_eff  = zero_max;
      clamp_now = 1'b1;
    end
  end

  // Terminal counts for the active and zero segments of the latched period.
  always_comb begin
    pos_last  = hp_sh - zero_sh - CNT_W'(1);
    zero_last = zero_sh - CNT_W'(1);
  end

  // Next-state selection; a period boundary (any entry into POS) requests a
  // fresh capture of the timing settings. Zero segments are skipped entirely
  // when the latched zero time is 0.
  always_comb begin
    nxt   = state;
    latch = 1'b0;
    if (!bus.i_enable) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          nxt   = POS;
          latch = 1'b1;
        end
        POS: begin
          if (cnt == pos_last) begin
            nxt = (zero_sh == '0) ? NEG : ZERO_A;
          end
        end
        ZERO_A: begin
          if (cnt == zero_last) begin
            nxt = NEG;
          end
        end
        NEG: begin
          if (cnt == pos_last) begin
            if (zero_sh == '0) begin
              nxt   = POS;
              latch = 1'b1;
            end else begin
              nxt = ZERO_B;
            end
          end
        end
        ZERO_B: begin
          if (cnt == zero_last) begin
            nxt   = POS;
            latch = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // State, tick counter, gate commands and sync pulse all update together.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mosfet_r <= '0;
      sync_r   <= 1'b0;
    end else begin
      state    <= nxt;
      mosfet_r <= leg_code(nxt);
      sync_r   <= (nxt == POS) && (state != POS);
      if ((nxt != state) || (nxt == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Shadow settings and clamp flag, captured only at period boundaries.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      hp_sh   <= '0;
      zero_sh <= '0;
      clamp_r <= 1'b0;
    end else if (latch) begin
      hp_sh   <= hp_eff;
      zero_sh <= zero_eff;
      clamp_r <= clamp_now;
    end
  end

  // Sticky shoot-through monitor on the registered gate commands.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      alert_r <= 1'b0;
    end else if ((mosfet_r[0] & mosfet_r[2]) | (mosfet_r[1] & mosfet_r[3])) begin
      alert_r <= 1'b1;
    end
  end

  assign bus.o_mosfet = mosfet_r;
  assign bus.o_state  = state;
  assign bus.o_sync   = sync_r;
  assign bus.o_clamp  = clamp_r;
  assign bus.o_alert  = alert_r;

endmodule
